// File: rtl/ps2_key_event_queue.sv
// ============================================================================
// Module      : ps2_key_event_queue
// Description : Folds PS/2 Set-2 scan bytes into key events and queues them.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ps2_key_event_queue #(
    parameter int C_DEPTH      = 16,
    parameter int C_COUNT_BITS = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [7:0]              SCAN_BYTE,
    input  logic                    SCAN_VALID,
    input  logic                    RD_EN,
    input  logic                    CLR_OVF,
    output logic [31:0]             RD_DATA,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic [C_COUNT_BITS-1:0] COUNT,
    output logic                    OVERFLOW,
    output logic                    INT_O
);

    localparam int PTR_W = $clog2(C_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        skip_q, skip_d;
    logic              wr_req;
    logic [10:0]       ev_word;

    logic [10:0]             mem_q [C_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [C_COUNT_BITS-1:0] count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    wr_do, rd_do, drop;

    // Host acknowledge/diagnostic bytes that carry no key information.
    function automatic logic is_filtered(input logic [7:0] b);
        case (b)
            8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_filtered = 1'b1;
            default:                                         is_filtered = 1'b0;
        endcase
    endfunction

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        wr_req  = 1'b0;
        ev_word = 11'd0;
        if (SCAN_VALID) begin
            case (state_q)
                ST_IDLE: begin
                    if (SCAN_BYTE == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (SCAN_BYTE == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (SCAN_BYTE == 8'hE1) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'd7;
                    end else if (!is_filtered(SCAN_BYTE)) begin
                        wr_req  = 1'b1;
                        ev_word = {3'b000, SCAN_BYTE};
                    end
                end
                ST_EXT: begin
                    if (SCAN_BYTE == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else if (SCAN_BYTE != 8'hE0) begin
                        wr_req  = 1'b1;
                        ev_word = {3'b010, SCAN_BYTE};
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (SCAN_BYTE == 8'hE0) begin
                        state_d = ST_EXT_BRK;
                    end else if (SCAN_BYTE != 8'hF0) begin
                        wr_req  = 1'b1;
                        ev_word = {3'b001, SCAN_BYTE};
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (SCAN_BYTE != 8'hF0 && SCAN_BYTE != 8'hE0) begin
                        wr_req  = 1'b1;
                        ev_word = {3'b011, SCAN_BYTE};
                        state_d = ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    // The pause sequence is swallowed whole; its last byte reports it.
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        wr_req  = 1'b1;
                        ev_word = {3'b100, 8'h77};
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = 3'd0;
                end
            endcase
        end
    end

    assign EMPTY = (count_q == '0);
    assign FULL  = (count_q == C_COUNT_BITS'(C_DEPTH));
    assign rd_do = RD_EN && !EMPTY;
    // A simultaneous pop frees a slot, so a full queue still accepts the write.
    assign wr_do = wr_req && (!FULL || rd_do);
    assign drop  = wr_req && FULL && !rd_do;

    always_comb begin
        count_d = count_q;
        case ({wr_do, rd_do})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_do) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_do) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_do) begin
            mem_q[wr_ptr_q] <= ev_word;
        end
    end

    assign RD_DATA  = EMPTY ? 32'd0 : {21'd0, mem_q[rd_ptr_q]};
    assign COUNT    = count_q;
    assign OVERFLOW = ovf_q;
    assign INT_O    = !EMPTY;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_event_queue.sv
// ============================================================================
// Module      : tb_ps2_key_event_queue
// Description : Directed self-checking bench for ps2_key_event_queue.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_key_event_queue;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  SCAN_BYTE = 8'h00;
    logic        SCAN_VALID = 1'b0;
    logic        RD_EN = 1'b0;
    logic        CLR_OVF = 1'b0;
    logic [31:0] RD_DATA;
    logic        EMPTY;
    logic        FULL;
    logic [4:0]  COUNT;
    logic        OVERFLOW;
    logic        INT_O;

    int vectors = 0;
    int miscompares = 0;

    ps2_key_event_queue #(.C_DEPTH(16), .C_COUNT_BITS(5)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SCAN_BYTE  (SCAN_BYTE),
        .SCAN_VALID (SCAN_VALID),
        .RD_EN      (RD_EN),
        .CLR_OVF    (CLR_OVF),
        .RD_DATA    (RD_DATA),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .COUNT      (COUNT),
        .OVERFLOW   (OVERFLOW),
        .INT_O      (INT_O)
    );

    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; outputs are inspected there too.
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        SCAN_BYTE  = b;
        SCAN_VALID = 1'b1;
        @(negedge CLK);
        SCAN_VALID = 1'b0;
    endtask

    task automatic pop();
        @(negedge CLK);
        RD_EN = 1'b1;
        @(negedge CLK);
        RD_EN = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({EMPTY, FULL, COUNT, OVERFLOW, INT_O, RD_DATA} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state: E=%b F=%b C=%0d O=%b I=%b D=%h, want E=1 F=0 C=0 O=0 I=0 D=0",
                     EMPTY, FULL, COUNT, OVERFLOW, INT_O, RD_DATA);
        end
    endtask

    task automatic test_plain();
        send_byte(8'h1C);
        vectors++;
        if ({RD_DATA, EMPTY, COUNT, INT_O} !== {32'h1C, 1'b0, 5'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL plain_1C: D=%h E=%b C=%0d I=%b, want D=0000001c E=0 C=1 I=1",
                     RD_DATA, EMPTY, COUNT, INT_O);
        end
        pop();
        vectors++;
        if ({EMPTY, INT_O, RD_DATA} !== {1'b1, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL plain_pop: E=%b I=%b D=%h, want E=1 I=0 D=0", EMPTY, INT_O, RD_DATA);
        end
    endtask

    task automatic test_prefixes();
        logic [31:0] exp_ev [3];
        exp_ev[0] = 32'h11C;
        exp_ev[1] = 32'h275;
        exp_ev[2] = 32'h375;
        send_byte(8'hF0);
        vectors++;
        if (COUNT !== 5'd0) begin
            miscompares++;
            $display("FAIL prefix_F0_count: got %0d want 0", COUNT);
        end
        send_byte(8'h1C);
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        vectors++;
        if (COUNT !== 5'd2) begin
            miscompares++;
            $display("FAIL prefix_E0F0_count: got %0d want 2", COUNT);
        end
        send_byte(8'h75);
        vectors++;
        if (COUNT !== 5'd3) begin
            miscompares++;
            $display("FAIL prefix_total_count: got %0d want 3", COUNT);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (RD_DATA !== exp_ev[i]) begin
                miscompares++;
                $display("FAIL prefix_event%0d: got %h want %h", i, RD_DATA, exp_ev[i]);
            end
            pop();
        end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 8; i++) begin
            send_byte(seq[i]);
        end
        vectors++;
        if (COUNT !== 5'd1 || RD_DATA !== 32'h477) begin
            miscompares++;
            $display("FAIL pause_event: C=%0d D=%h, want C=1 D=00000477", COUNT, RD_DATA);
        end
        send_byte(8'h1C);
        pop();
        vectors++;
        if (COUNT !== 5'd1 || RD_DATA !== 32'h01C) begin
            miscompares++;
            $display("FAIL pause_then_idle: C=%0d D=%h, want C=1 D=0000001c", COUNT, RD_DATA);
        end
        pop();
    endtask

    task automatic test_filter_reset();
        send_byte(8'hAA);
        send_byte(8'hFA);
        send_byte(8'h00);
        vectors++;
        if (COUNT !== 5'd0 || EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL filter_bytes: C=%0d E=%b, want C=0 E=1", COUNT, EMPTY);
        end
        send_byte(8'hE0);
        // Pulse reset between clock edges to exercise the asynchronous path.
        #2 RESET = 1'b1;
        #1;
        vectors++;
        if (COUNT !== 5'd0 || OVERFLOW !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: C=%0d O=%b, want C=0 O=0", COUNT, OVERFLOW);
        end
        #1 RESET = 1'b0;
        send_byte(8'h75);
        vectors++;
        if (RD_DATA !== 32'h075 || COUNT !== 5'd1) begin
            miscompares++;
            $display("FAIL reset_mid_seq: D=%h C=%0d, want D=00000075 C=1", RD_DATA, COUNT);
        end
        pop();
    endtask

    task automatic test_full();
        logic [7:0] exp_b;
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            send_byte(8'(i));
        end
        vectors++;
        if ({FULL, COUNT, OVERFLOW, RD_DATA} !== {1'b1, 5'd16, 1'b1, 32'h001}) begin
            miscompares++;
            $display("FAIL full_flags: F=%b C=%0d O=%b D=%h, want F=1 C=16 O=1 D=00000001",
                     FULL, COUNT, OVERFLOW, RD_DATA);
        end
        @(negedge CLK);
        CLR_OVF = 1'b1;
        @(negedge CLK);
        CLR_OVF = 1'b0;
        vectors++;
        if (OVERFLOW !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_ovf: got %b want 0", OVERFLOW);
        end
        @(negedge CLK);
        SCAN_BYTE  = 8'h13;
        SCAN_VALID = 1'b1;
        CLR_OVF    = 1'b1;
        @(negedge CLK);
        SCAN_VALID = 1'b0;
        CLR_OVF    = 1'b0;
        vectors++;
        if (OVERFLOW !== 1'b1 || COUNT !== 5'd16) begin
            miscompares++;
            $display("FAIL drop_beats_clear: O=%b C=%0d, want O=1 C=16", OVERFLOW, COUNT);
        end
        @(negedge CLK);
        SCAN_BYTE  = 8'h12;
        SCAN_VALID = 1'b1;
        RD_EN      = 1'b1;
        @(negedge CLK);
        SCAN_VALID = 1'b0;
        RD_EN      = 1'b0;
        vectors++;
        if (COUNT !== 5'd16 || FULL !== 1'b1 || RD_DATA !== 32'h002) begin
            miscompares++;
            $display("FAIL full_wr_rd: C=%0d F=%b D=%h, want C=16 F=1 D=00000002", COUNT, FULL, RD_DATA);
        end
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(i + 2) : 8'h12;
            vectors++;
            if (RD_DATA !== {24'd0, exp_b}) begin
                miscompares++;
                $display("FAIL full_drain%0d: got %h want %h", i, RD_DATA, {24'd0, exp_b});
            end
            pop();
        end
        vectors++;
        if (EMPTY !== 1'b1 || COUNT !== 5'd0) begin
            miscompares++;
            $display("FAIL full_drained: E=%b C=%0d, want E=1 C=0", EMPTY, COUNT);
        end
    endtask

    task automatic test_empty_read();
        pop();
        vectors++;
        if (COUNT !== 5'd0 || EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL read_empty: C=%0d E=%b, want C=0 E=1", COUNT, EMPTY);
        end
        @(negedge CLK);
        SCAN_BYTE  = 8'h2A;
        SCAN_VALID = 1'b1;
        RD_EN      = 1'b1;
        @(negedge CLK);
        SCAN_VALID = 1'b0;
        RD_EN      = 1'b0;
        vectors++;
        if (COUNT !== 5'd1 || RD_DATA !== 32'h02A) begin
            miscompares++;
            $display("FAIL write_on_empty_rd: C=%0d D=%h, want C=1 D=0000002a", COUNT, RD_DATA);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [$];
        logic [7:0] b;
        for (int i = 0; i < 3; i++) begin
            b = 8'(8'h20 + i);
            send_byte(b);
            q.push_back(b);
        end
        for (int i = 3; i < 43; i++) begin
            @(negedge CLK);
            vectors++;
            if (RD_DATA !== {24'd0, q[0]}) begin
                miscompares++;
                $display("FAIL wrap_pair%0d: got %h want %h", i - 3, RD_DATA, {24'd0, q[0]});
            end
            b          = 8'(8'h20 + i);
            SCAN_BYTE  = b;
            SCAN_VALID = 1'b1;
            RD_EN      = 1'b1;
            void'(q.pop_front());
            q.push_back(b);
        end
        @(negedge CLK);
        SCAN_VALID = 1'b0;
        RD_EN      = 1'b0;
        while (q.size() > 0) begin
            vectors++;
            if (RD_DATA !== {24'd0, q[0]} || COUNT !== 5'(q.size())) begin
                miscompares++;
                $display("FAIL wrap_drain: D=%h C=%0d, want D=%h C=%0d",
                         RD_DATA, COUNT, {24'd0, q[0]}, q.size());
            end
            void'(q.pop_front());
            pop();
        end
        vectors++;
        if (EMPTY !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_empty: E=%b want 1", EMPTY);
        end
    endtask

    initial begin
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        test_reset();
        test_plain();
        test_prefixes();
        test_pause();
        test_filter_reset();
        test_full();
        test_empty_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
